// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard sequence controller:
//   - kbd_state_e : scan-code sequencer states
//   - scan-code constants (break prefix, extended prefix, shift keys, caps lock)
//   - ASCII_NONE  : converter result meaning "no character for this key"
//   - helpers for shift-key detection and letter case folding
// -----------------------------------------------------------------------------
package kbd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,  // waiting for a make code or a prefix
    BRK     = 3'd1,  // F0 seen, next byte is the released key
    EXT     = 3'd2,  // E0 seen, extended key follows
    EXT_BRK = 3'd3,  // E0 F0 seen, next byte is a released extended key
    LOOKUP  = 3'd4,  // scan code presented to the converter
    PUSH    = 3'd5   // converted character goes to the FIFO
  } kbd_state_e;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] ASCII_NONE = 8'hFF;

  localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  function automatic logic is_shift_code(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
  endfunction

  // The converter only returns uppercase letters; lowercase is produced here
  // unless exactly one of shift / caps lock is active.
  function automatic logic [7:0] fold_case(input logic [7:0] ch, input logic upper);
    if (!upper && (ch >= ASCII_UPPER_A) && (ch <= ASCII_UPPER_Z)) begin
      return ch + ASCII_CASE_OFS;
    end
    return ch;
  endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// -----------------------------------------------------------------------------
// kbd_char_fifo
// Synchronous FIFO with a combinational head (first-word fall-through).
// A write to a full FIFO is accepted when a read happens in the same cycle;
// a read from an empty FIFO is ignored, so push+pop on empty writes only.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (data width)
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en_i          write request, wr_data_i written when accepted
//   rd_en_i          pop request, honoured only when not empty
//   rd_data_o        head entry, all zeros while empty
//   full_o, empty_o  occupancy flags
// -----------------------------------------------------------------------------
module kbd_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             rd_fire;
  logic             wr_fire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == COUNT_FULL);
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap by overflow.
      if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the head is masked while empty, and leaving it unreset lets it
  // map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/kbd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// kbd_seq_ctrl
// Turns a stream of PS/2 scan-code bytes into ASCII characters.
// Tracks break (F0) and extended (E0) prefixes, shift keys and caps lock,
// asks an external scan-code-to-ASCII converter for each make code, applies
// case folding and queues the result in a character FIFO.
//
// Build option: KBD_TYPEMATIC_EN
//   defined   - every make of a held key emits a character (auto-repeat)
//   undefined - a repeated make of the held key is ignored until its break
//
// Ports:
//   clk, clrn             clock, asynchronous active-low reset
//   code, code_valid      scan-code byte and its one-cycle strobe
//   code_ready            byte accepted this cycle (prefix/idle states only)
//   lut_code, lut_ascii   converter request (held between lookups) / result
//   char_out, char_valid  FIFO head and not-empty flag
//   char_ready            consumer pop
//   shift_on, caps_on     modifier state
//   overflow              sticky: a character was dropped on a full FIFO
// -----------------------------------------------------------------------------
module kbd_seq_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] lut_code,
  input  logic [7:0] lut_ascii,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       shift_on,
  output logic       caps_on,
  output logic       overflow
);

  kbd_state_e state_q, state_d;
  logic [7:0] lut_code_q, lut_code_d;  // latched make code, drives lut_code
  logic [7:0] ascii_q, ascii_d;        // converter result sampled in LOOKUP
  logic [7:0] held_q, held_d;          // last key that went through PUSH
  logic       shift_q, shift_d;
  logic       caps_q, caps_d;
  logic       ovf_q, ovf_d;

  logic       accept;
  logic       pop;
  logic       push_req;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] push_char;

  assign code_ready = (state_q == IDLE) || (state_q == BRK) ||
                      (state_q == EXT)  || (state_q == EXT_BRK);
  assign accept     = code_valid && code_ready;
  assign pop        = char_valid && char_ready;
  assign push_char  = fold_case(ascii_q, shift_q ^ caps_q);

  // NOTE: every signal driven here gets its default before the case
  // statement, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lut_code_d = lut_code_q;
    ascii_d    = ascii_q;
    held_d     = held_q;
    shift_d    = shift_q;
    caps_d     = caps_q;
    ovf_d      = ovf_q;
    push_req   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (code == SC_BREAK) begin
            state_d = BRK;
          end else if (code == SC_EXT) begin
            state_d = EXT;
          end else if (is_shift_code(code)) begin
            shift_d = 1'b1;
          end else if (code == SC_CAPS) begin
            caps_d = ~caps_q;
          end else begin
`ifdef KBD_TYPEMATIC_EN
            lut_code_d = code;
            state_d    = LOOKUP;
`else
            // Auto-repeat of the held key is suppressed before the lookup.
            if (code != held_q) begin
              lut_code_d = code;
              state_d    = LOOKUP;
            end
`endif
          end
        end
      end

      BRK: begin
        if (accept) begin
          state_d = IDLE;
          if (is_shift_code(code)) begin
            shift_d = 1'b0;
          end else if (code == held_q) begin
            held_d = 8'h00;
          end
        end
      end

      EXT: begin
        if (accept) begin
          state_d = (code == SC_BREAK) ? EXT_BRK : IDLE;
        end
      end

      EXT_BRK: begin
        if (accept) state_d = IDLE;
      end

      LOOKUP: begin
        ascii_d = lut_ascii;
        state_d = PUSH;
      end

      PUSH: begin
        held_d  = lut_code_q;
        state_d = IDLE;
        if (ascii_q != ASCII_NONE) begin
          push_req = 1'b1;
          // A full FIFO still takes the write if the consumer pops now.
          if (fifo_full && !pop) ovf_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      lut_code_q <= 8'h00;
      ascii_q    <= 8'h00;
      held_q     <= 8'h00;
      shift_q    <= 1'b0;
      caps_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lut_code_q <= lut_code_d;
      ascii_q    <= ascii_d;
      held_q     <= held_d;
      shift_q    <= shift_d;
      caps_q     <= caps_d;
      ovf_q      <= ovf_d;
    end
  end

  kbd_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (clrn),
    .wr_en_i   (push_req),
    .wr_data_i (push_char),
    .rd_en_i   (char_ready),
    .rd_data_o (char_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign char_valid = !fifo_empty;
  assign lut_code   = lut_code_q;
  assign shift_on   = shift_q;
  assign caps_on    = caps_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_kbd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kbd_seq_ctrl
// Directed scenarios followed by a random scan-code stream for kbd_seq_ctrl.
// The bench provides the scan-code-to-ASCII converter and keeps a keyboard
// model (prefix flags, modifiers, held key, expected character queue).
// -----------------------------------------------------------------------------
module tb_kbd_seq_ctrl;

  localparam int DEPTH = 8;
`ifdef KBD_TYPEMATIC_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] lut_code;
  logic [7:0] lut_ascii;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       shift_on;
  logic       caps_on;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // keyboard model
  logic [7:0] q_exp [$];
  bit         m_shift, m_caps, m_brk, m_ext, m_ovf;
  logic [7:0] m_held;

  kbd_seq_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .lut_code   (lut_code),
    .lut_ascii  (lut_ascii),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .shift_on   (shift_on),
    .caps_on    (caps_on),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Converter: letters map to uppercase, a few digits and space, else FF.
  function automatic logic [7:0] conv(input logic [7:0] sc);
    for (int i = 0; i < 26; i++) begin
      if (LETTERS[i] == sc) return 8'h41 + 8'(i);
    end
    case (sc)
      8'h16:   return 8'h31;
      8'h1E:   return 8'h32;
      8'h26:   return 8'h33;
      8'h29:   return 8'h20;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb lut_ascii = conv(lut_code);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_shift = 0; m_caps = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
    m_held  = 8'h00;
  endtask

  // Effect of one accepted byte on the keyboard model.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    if (m_ext && m_brk) begin
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      else if (b == m_held)         m_held  = 8'h00;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else            m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'h12 || b == 8'h59) begin
      m_shift = 1;
    end else if (b == 8'h58) begin
      m_caps = !m_caps;
    end else if (TYPEMATIC || b != m_held) begin
      m_held = b;
      a = conv(b);
      if (a != 8'hFF) begin
        if (a >= 8'h41 && a <= 8'h5A && !(m_shift ^ m_caps)) a = a + 8'h20;
        if (q_exp.size() < DEPTH) q_exp.push_back(a);
        else                      m_ovf = 1;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!code_ready && n < 8) begin
      tick();
      n++;
    end
    if (!code_ready) check({tag, "_ready_timeout"}, code_ready, 1);
  endtask

  // Send one byte and wait until the sequencer can take the next one.
  task automatic send_byte(input logic [7:0] b);
    wait_ready("send");
    code = b; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    model_byte(b);
    wait_ready("settle");
  endtask

  task automatic key(input logic [7:0] b);
    send_byte(b);
    send_byte(8'hF0);
    send_byte(b);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_valid"}, char_valid, 1);
    check({tag, "_char"}, char_out, q_exp[0]);
    void'(q_exp.pop_front());
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q_exp.size() > 0) pop_one(tag);
    check({tag, "_empty"}, char_valid, 0);
  endtask

  // Make code whose PUSH cycle coincides with a consumer pop.
  task automatic make_with_pop(input string tag, input logic [7:0] b);
    wait_ready(tag);
    code = b; code_valid = 1'b1;
    tick();                     // byte accepted, now LOOKUP
    code_valid = 1'b0;
    tick();                     // now PUSH
    check({tag, "_busy"}, code_ready, 0);
    char_ready = 1'b1;
    if (q_exp.size() > 0) begin
      check({tag, "_head"}, char_out, q_exp[0]);
      void'(q_exp.pop_front());
    end
    tick();                     // push and pop on the same edge
    char_ready = 1'b0;
    model_byte(b);
    send_byte(8'hF0);
    send_byte(b);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    #3;
    model_reset();
    tick();
    clrn = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    code = 8'h00; code_valid = 1'b0; char_ready = 1'b0;
    model_reset();

    // Reset values
    clrn = 1'b0;
    #12;
    check("rst_char_valid", char_valid, 0);
    check("rst_char_out",   char_out,   8'h00);
    check("rst_lut_code",   lut_code,   8'h00);
    check("rst_shift",      shift_on,   0);
    check("rst_caps",       caps_on,    0);
    check("rst_overflow",   overflow,   0);
    check("rst_code_ready", code_ready, 1);
    tick();
    clrn = 1'b1;
    tick();

    // Plain lowercase letter
    key(8'h1C);
    check("a_lut_hold", lut_code, 8'h1C);
    check("a_shift", shift_on, 0);
    check("a_caps",  caps_on,  0);
    check("a_char",  char_out, 8'h61);
    drain("a");

    // Shifted letter
    send_byte(8'h12);
    check("shift_held", shift_on, 1);
    key(8'h1C);
    check("shift_during", shift_on, 1);
    send_byte(8'hF0);
    send_byte(8'h12);
    check("shift_released", shift_on, 0);
    check("shift_char", char_out, 8'h41);
    drain("shift");

    // Caps lock: digit unchanged, letter uppercase, caps+shift lowercase
    key(8'h58);
    check("caps_on", caps_on, 1);
    key(8'h16);
    check("caps_digit", char_out, 8'h31);
    drain("caps_digit");
    key(8'h1C);
    send_byte(8'h59);
    key(8'h32);
    key(8'h59);
    drain("caps_mix");
    key(8'h58);
    check("caps_off", caps_on, 0);

    // Repeated make of the held key
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    n = 0;
    while (char_valid && n < 10) begin
      check("rep_char", char_out, 8'h61);
      char_ready = 1'b1;
      tick();
      char_ready = 1'b0;
      n++;
    end
    check("rep_count", n, TYPEMATIC ? 3 : 1);
    q_exp.delete();

    // Overflow: DEPTH+1 letters without popping
    for (int i = 0; i <= DEPTH; i++) key(LETTERS[i]);
    check("ovf_flag",  overflow, m_ovf);
    check("ovf_first", char_out, 8'h61);
    drain("ovf");
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);

    // Push and pop in the same cycle, full then empty FIFO
    for (int i = 0; i < DEPTH; i++) key(LETTERS[i + 2]);
    check("full_valid", char_valid, 1);
    make_with_pop("full_pp", LETTERS[20]);
    check("full_pp_ovf", overflow, 0);
    drain("full_pp");
    make_with_pop("empty_pp", LETTERS[21]);
    check("empty_pp_valid", char_valid, 1);
    drain("empty_pp");

    // Extended keys, unmapped code, then reset during LOOKUP
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    key(8'h07);
    check("ext_none", char_valid, 0);
    wait_ready("midrst");
    code = 8'h1C; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("midrst_lookup", lut_code, 8'h1C);
    clrn = 1'b0;
    #1;
    check("midrst_lut",    lut_code,   8'h00);
    check("midrst_valid",  char_valid, 0);
    check("midrst_char",   char_out,   8'h00);
    check("midrst_shift",  shift_on,   0);
    check("midrst_caps",   caps_on,    0);
    check("midrst_ovf",    overflow,   0);
    check("midrst_ready",  code_ready, 1);
    model_reset();
    tick();
    clrn = 1'b1;
    tick(); tick(); tick();
    check("midrst_nochar", char_valid, 0);

    // Random byte stream
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: b = LETTERS[$urandom_range(0, 25)];
        4:          b = 8'hF0;
        5:          b = 8'hE0;
        6:          b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        7:          b = 8'h58;
        8:          b = ($urandom_range(0, 1) != 0) ? 8'h16 : 8'h29;
        default:    b = 8'h07;
      endcase
      send_byte(b);
      check("rnd_shift", shift_on, m_shift);
      check("rnd_caps",  caps_on,  m_caps);
      check("rnd_ovf",   overflow, m_ovf);
      if ($urandom_range(0, 3) == 0) drain("rnd");
    end
    drain("rnd_final");
    check("rnd_final_ovf", overflow, m_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_seq_ctrl.md
KBD_SEQ_CTRL -- requirements
Module: kbd_seq_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output character FIFO depth; power of two, 2..32.
REQ-002 Port clk, input, 1, system clock; all state updates on posedge clk.
REQ-003 Port clrn, input, 1, reset; asynchronous, active-low.
REQ-004 Port code, input, 8, PS/2 scan-code byte from the receiver.
REQ-005 Port code_valid, input, 1, code is valid this cycle; one-cycle pulse per byte.
REQ-006 Port code_ready, output, 1, the block accepts code this cycle.
REQ-007 Port lut_code, output, 8, scan code presented to the scan-code-to-ASCII converter.
REQ-008 Port lut_ascii, input, 8, converter result: uppercase letters; 8'hFF means unmapped.
REQ-009 Port char_out, output, 8, ASCII character at the FIFO head.
REQ-010 Port char_valid, output, 1, FIFO not empty.
REQ-011 Port char_ready, input, 1, consumer pop; a pop occurs when char_valid and char_ready are both high.
REQ-012 Port shift_on, output, 1, a shift key is held.
REQ-013 Port caps_on, output, 1, caps-lock state.
REQ-014 Port overflow, output, 1, sticky; set when a character is dropped because the FIFO is full.

Function
REQ-015 The FSM SHALL have the states IDLE, BRK, EXT, EXT_BRK, LOOKUP and PUSH.
REQ-016 code_ready SHALL be high only in IDLE, BRK, EXT and EXT_BRK.
REQ-017 On an accepted byte, IDLE SHALL transition as follows: F0 -> BRK; E0 -> EXT; 12/59 -> set shift_on, stay in IDLE; 58 -> toggle caps_on; any other byte -> LOOKUP.
REQ-018 In BRK, an accepted byte SHALL return the FSM to IDLE; 12/59 SHALL clear shift_on; any other byte SHALL clear the held-key register if it matches.
REQ-019 In EXT, F0 SHALL go to EXT_BRK; any other byte SHALL be discarded and return the FSM to IDLE; extended keys emit nothing.
REQ-020 In EXT_BRK, any byte SHALL return the FSM to IDLE.
REQ-021 In LOOKUP, the block SHALL drive lut_code with the latched byte for exactly one cycle and sample lut_ascii at the end of that cycle, then go to PUSH.
REQ-022 lut_code SHALL hold its last value outside LOOKUP.
REQ-023 In PUSH, 8'hFF SHALL be discarded; for "A"-"Z", the block SHALL add 8'h20 when shift_on XOR caps_on is 0; all other characters SHALL pass unchanged.
REQ-024 PUSH SHALL write the character to the FIFO if it is not full; otherwise it SHALL drop the character and set overflow. PUSH then SHALL return to IDLE (2-cycle code-to-push latency).
REQ-025 PUSH SHALL record the byte in the held-key register.
REQ-026 A simultaneous push and pop on a full FIFO SHALL succeed; a simultaneous push and pop on an empty FIFO SHALL write only.
REQ-027 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 char_out SHALL be valid combinationally from the FIFO head.

Reset
REQ-029 When clrn is low, the FSM SHALL be in IDLE; FIFO empty; char_valid=0; char_out=8'h00; lut_code=8'h00; shift_on=0; caps_on=0; overflow=0; held-key=8'h00.
REQ-030 A reset mid-sequence (e.g. in BRK or LOOKUP) SHALL abandon the sequence; no partial character is written.
REQ-031 overflow SHALL be cleared only by reset.

Configuration
REQ-032 With macro KBD_TYPEMATIC_EN defined, a repeated make of the held key SHALL emit a character each time.
REQ-033 Without KBD_TYPEMATIC_EN, a make whose byte equals the held-key register SHALL be discarded in IDLE without a lookup, until its break clears the register.

Structure
REQ-034 The shared package kbd_pkg SHALL hold the state enum and the constants SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58 and ASCII_NONE=FF.
REQ-035 The FIFO SHALL be a sub-module, kbd_char_fifo, parameterised by depth and width.

Verification
REQ-036 1C, F0 1C with caps=0, shift=0 -> one pop yields 8'h61 "a".
REQ-037 12, 1C, F0 1C, F0 12 -> yields 8'h41; shift_on=1 during the key, 0 afterwards.
REQ-038 58, F0 58, 16 -> caps_on=1; yields 8'h31 "1", unchanged.
REQ-039 With char_ready=0, send FIFO_DEPTH+1 letters -> FIFO_DEPTH chars held, overflow=1; first pop returns the first letter.
REQ-040 1C, 1C, 1C, F0 1C -> three chars with KBD_TYPEMATIC_EN, one without.
REQ-041 E0 75, E0 F0 75, then 07 (lookup FF), then clrn pulse during LOOKUP -> FIFO empty, all outputs at reset values.
